// File: rtl/button_debouncer.sv
// Push-button conditioner: two-flop synchroniser followed by a bounce-rejecting FSM.
// buttonClean is the registered pressed level; bounceEvt pulses for one cycle on every aborted change.
module button_debouncer #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 20,
    parameter bit ACTIVE_LOW    = 1'b0
) (
    input  logic Clk,
    input  logic Rst,
    input  logic buttonRaw,
    output logic buttonClean,
    output logic bounceEvt
);

    typedef enum logic [1:0] {
        S_RELEASED      = 2'b00,
        S_PRESS_CHECK   = 2'b01,
        S_PRESSED       = 2'b10,
        S_RELEASE_CHECK = 2'b11
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

    logic                 norm;
    logic                 sync1_q;
    logic                 sync2_q;
    state_t               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 bounce_q;

    assign norm  = buttonRaw ^ ACTIVE_LOW;
    assign cnt_d = cnt_q + 1'b1;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            state_q  <= S_RELEASED;
            cnt_q    <= '0;
            bounce_q <= 1'b0;
        end else begin
            sync1_q  <= norm;
            sync2_q  <= sync1_q;
            bounce_q <= 1'b0;
            case (state_q)
                S_RELEASED: begin
                    cnt_q <= '0;
                    if (sync2_q) state_q <= S_PRESS_CHECK;
                end
                S_PRESS_CHECK: begin
                    if (!sync2_q) begin
                        state_q  <= S_RELEASED;
                        cnt_q    <= '0;
                        bounce_q <= 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= S_PRESSED;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                S_PRESSED: begin
                    cnt_q <= '0;
                    if (!sync2_q) state_q <= S_RELEASE_CHECK;
                end
                S_RELEASE_CHECK: begin
                    if (sync2_q) begin
                        state_q  <= S_PRESSED;
                        cnt_q    <= '0;
                        bounce_q <= 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= S_RELEASED;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: begin
                    // Recover from any corrupted encoding into the idle state.
                    state_q <= S_RELEASED;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign buttonClean = state_q[1];
    assign bounceEvt   = bounce_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: three instances (default, active-low, single-cycle qualify)
// checked every cycle against a run-length reference model, plus directed latency checks.
module tb_button_debouncer;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic [2:0] raw = 3'b000;
    logic       clean [3];
    logic       bev   [3];

    int n_checks = 0;
    int n_errors = 0;
    int bev_cnt  = 0;

    localparam int STAB [3] = '{4, 4, 1};
    localparam bit AL   [3] = '{1'b0, 1'b1, 1'b0};

    // Reference state: delay line of normalised samples, accepted level, mismatch run length.
    bit m_d1    [3];
    bit m_d2    [3];
    bit m_clean [3];
    bit m_bev   [3];
    int m_run   [3];

    always #5 Clk = ~Clk;

    button_debouncer #(.STABLE_CYCLES(4), .CNT_WIDTH(20), .ACTIVE_LOW(1'b0)) dut0 (
        .Clk(Clk), .Rst(Rst), .buttonRaw(raw[0]), .buttonClean(clean[0]), .bounceEvt(bev[0]));
    button_debouncer #(.STABLE_CYCLES(4), .CNT_WIDTH(20), .ACTIVE_LOW(1'b1)) dut1 (
        .Clk(Clk), .Rst(Rst), .buttonRaw(raw[1]), .buttonClean(clean[1]), .bounceEvt(bev[1]));
    button_debouncer #(.STABLE_CYCLES(1), .CNT_WIDTH(4), .ACTIVE_LOW(1'b0)) dut2 (
        .Clk(Clk), .Rst(Rst), .buttonRaw(raw[2]), .buttonClean(clean[2]), .bounceEvt(bev[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // A change is accepted once the FSM input has disagreed with the accepted
    // level on STAB+1 consecutive edges; an earlier agreement is a bounce.
    task automatic model_edge(input int k, input bit r, input bit rst);
        bit s;
        if (rst) begin
            m_d1[k] = 0; m_d2[k] = 0; m_clean[k] = 0; m_bev[k] = 0; m_run[k] = 0;
        end else begin
            s = m_d2[k];
            m_bev[k] = 0;
            if (s != m_clean[k]) begin
                m_run[k]++;
                if (m_run[k] == STAB[k] + 1) begin
                    m_clean[k] = ~m_clean[k];
                    m_run[k] = 0;
                end
            end else begin
                if (m_run[k] > 0) m_bev[k] = 1;
                m_run[k] = 0;
            end
            m_d2[k] = m_d1[k];
            m_d1[k] = r ^ AL[k];
        end
    endtask

    task automatic tick(input logic [2:0] r, input logic rst);
        raw = r;
        Rst = rst;
        @(posedge Clk);
        for (int k = 0; k < 3; k++) model_edge(k, r[k], rst);
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("clean%0d", k), 32'(clean[k]), 32'(m_clean[k]));
            check($sformatf("bounce%0d", k), 32'(bev[k]), 32'(m_bev[k]));
        end
        if (bev[0]) bev_cnt++;
    endtask

    // Pressed-level vector: instance 1 is active-low, so its pin is inverted.
    function automatic logic [2:0] lv(input logic pressed);
        return {pressed, ~pressed, pressed};
    endfunction

    initial begin
        int  e_r0, e_r1, min_clean;
        logic [2:0] rv;
        int  seg;

        // Test 1: reset with the pin pressed, then release reset.
        tick(lv(1), 1);
        tick(lv(1), 1);
        check("rst_clean", 32'(clean[0]), 0);
        check("rst_bounce", 32'(bev[0]), 0);
        check("rst_clean_al", 32'(clean[1]), 0);
        e_r0 = 0;
        for (int e = 1; e <= 12; e++) begin
            tick(lv(1), 0);
            if (clean[0] && e_r0 == 0) e_r0 = e;
        end
        check("t1_rise_edge", e_r0, 7);

        // Test 2 and 6: clean release then clean press, both polarities.
        bev_cnt = 0;
        e_r0 = 0; e_r1 = 0;
        for (int e = 1; e <= 12; e++) begin
            tick(lv(0), 0);
            if (!clean[0] && e_r0 == 0) e_r0 = e;
            if (!clean[1] && e_r1 == 0) e_r1 = e;
        end
        check("t2_fall_edge", e_r0, 7);
        check("t6_fall_edge_al", e_r1, 7);
        e_r0 = 0; e_r1 = 0;
        for (int e = 1; e <= 20; e++) begin
            tick(lv(1), 0);
            if (clean[0] && e_r0 == 0) e_r0 = e;
            if (clean[1] && e_r1 == 0) e_r1 = e;
        end
        check("t2_rise_edge", e_r0, 7);
        check("t6_rise_edge_al", e_r1, 7);
        for (int e = 1; e <= 12; e++) tick(lv(0), 0);
        check("t2_no_bounce", bev_cnt, 0);
        check("t2_released", 32'(clean[0]), 0);

        // Test 3: press bounce 1,1,0 then held at 1.
        bev_cnt = 0;
        tick(lv(1), 0);
        tick(lv(1), 0);
        tick(lv(0), 0);
        e_r0 = 0;
        for (int e = 1; e <= 12; e++) begin
            tick(lv(1), 0);
            if (clean[0] && e_r0 == 0) e_r0 = e;
        end
        check("t3_bounce_count", bev_cnt, 1);
        check("t3_rise_edge", e_r0, 7);

        // Test 4: release bounce of two low cycles while pressed.
        bev_cnt = 0;
        min_clean = 1;
        tick(lv(0), 0);
        if (!clean[0]) min_clean = 0;
        tick(lv(0), 0);
        if (!clean[0]) min_clean = 0;
        for (int e = 1; e <= 12; e++) begin
            tick(lv(1), 0);
            if (!clean[0]) min_clean = 0;
        end
        check("t4_no_dip", min_clean, 1);
        check("t4_bounce_count", bev_cnt, 1);

        // Test 5: reset while mid-way through a press check (cnt=2).
        for (int e = 1; e <= 12; e++) tick(lv(0), 0);
        for (int e = 1; e <= 5; e++) tick(lv(1), 0);
        tick(lv(1), 1);
        check("t5_clean_after_rst", 32'(clean[0]), 0);
        e_r0 = 0;
        for (int e = 1; e <= 12; e++) begin
            tick(lv(1), 0);
            if (clean[0] && e_r0 == 0) e_r0 = e;
        end
        check("t5_requal_edge", e_r0, 7);

        // Randomised segments: independent pin levels per instance, occasional reset.
        for (seg = 0; seg < 400; seg++) begin
            rv = 3'($urandom_range(0, 7));
            for (int c = $urandom_range(1, 9); c > 0; c--)
                tick(rv, ($urandom_range(0, 99) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
